mem_port_arb: RTL and testbench

- Arbitrates the core's instruction-fetch port and data load/store port onto one shared single-outstanding memory port.
- Generates the core's stall_if and stall_mem from transaction progress.
- Returns fetched instructions and load data to the core.
- Sits between core and the memory/bus bridge; one transaction in flight at a time.

---
 rtl/mem_port_arb_pkg.sv | 22 ++
 rtl/mem_port_arb_timeout_cnt.sv | 32 +++
 rtl/mem_port_arb.sv | 157 +++++++++++++++
 tb/tb_mem_port_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// FSM encodings, default bus widths and the timeout counter sizing helper.
package mem_port_arb_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_IF_WAIT = 2'd1;
  localparam logic [1:0] ARB_WR_WAIT = 2'd2;
  localparam logic [1:0] ARB_RD_WAIT = 2'd3;

  localparam int BUS_ADDR_MEM   = 64;
  localparam int BUS_DATA_MEM   = 64;
  localparam int BUS_AXI_STRB   = BUS_DATA_MEM / 8;
  localparam int BUS_DATA_INSTR = 32;

  localparam int DEF_TIMEOUT_CYC = 255;

  // A limit of 0 disables the timeout but still needs a 1-bit counter.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arb_timeout_cnt.sv
// Saturating wait-cycle counter; expired flags the no-ack cycle that reaches
// the configured limit so the arbiter can abort on that same edge.
module arb_timeout_cnt
  import mem_port_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is always updated with <=, so every always_ff
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (LIMIT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates core fetch and load/store requests onto one single-outstanding
// memory port and derives the fetch/data stalls from transaction progress.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_MEM,
  parameter int DATA_W      = BUS_DATA_MEM,
  parameter int INSTR_W     = BUS_DATA_INSTR,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_rd_en_i,
  input  logic [ADDR_W-1:0]   addr_instr_i,
  input  logic                mem_rd_en_i,
  input  logic                mem_wr_en_i,
  input  logic [ADDR_W-1:0]   addr_mem_rd_i,
  input  logic [ADDR_W-1:0]   addr_mem_wr_i,
  input  logic [DATA_W-1:0]   data_mem_wr_i,
  input  logic [DATA_W/8-1:0] strb_mem_wr_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [DATA_W-1:0]   data_mem_o,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_strb_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i
);

  logic [1:0] state;
  logic       if_rdy;
  logic       mem_rdy;
  logic       wr_done;   // store of a store+load pair finished, load still owed
  logic       ack;
  logic       expired;
  logic       if_pend;
  logic       wr_pend;
  logic       rd_pend;
  logic [INSTR_W-1:0] instr_sel;

  assign ack     = mem_req_o & mem_ack_i;
  assign if_pend = instr_rd_en_i & ~if_rdy;
  assign wr_pend = mem_wr_en_i & ~mem_rdy & ~wr_done;
  assign rd_pend = mem_rd_en_i & ~mem_rdy;

  assign stall_if  = instr_rd_en_i & ~if_rdy;
  assign stall_mem = (mem_rd_en_i | mem_wr_en_i) & ~mem_rdy;

  assign instr_sel = mem_addr_o[2] ? mem_rdata_i[DATA_W-1 -: INSTR_W]
                                   : mem_rdata_i[INSTR_W-1:0];

  arb_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == ARB_IDLE) | mem_ack_i),
    .en      ((state != ARB_IDLE) & ~mem_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      if_rdy      <= 1'b0;
      mem_rdy     <= 1'b0;
      wr_done     <= 1'b0;
      bus_err_o   <= 1'b0;
      instr_o     <= '0;
      data_mem_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_strb_o  <= '0;
    end else begin
      if_rdy    <= 1'b0;
      mem_rdy   <= 1'b0;
      bus_err_o <= 1'b0;
      wr_done   <= wr_done & (mem_rd_en_i | mem_wr_en_i);

      if (state == ARB_IDLE) begin
        // Data accesses belong to an older instruction, so they win over fetch.
        if (wr_pend) begin
          state       <= ARB_WR_WAIT;
          mem_req_o   <= 1'b1;
          mem_we_o    <= 1'b1;
          mem_addr_o  <= addr_mem_wr_i;
          mem_wdata_o <= data_mem_wr_i;
          mem_strb_o  <= strb_mem_wr_i;
        end else if (rd_pend) begin
          state       <= ARB_RD_WAIT;
          mem_req_o   <= 1'b1;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= addr_mem_rd_i;
          mem_wdata_o <= '0;
          mem_strb_o  <= '0;
        end else if (if_pend) begin
          state       <= ARB_IF_WAIT;
          mem_req_o   <= 1'b1;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= addr_instr_i;
          mem_wdata_o <= '0;
          mem_strb_o  <= '0;
        end
      end else if (ack) begin
        state     <= ARB_IDLE;
        mem_req_o <= 1'b0;
        case (state)
          ARB_IF_WAIT: begin
            // A pc that moved while the fetch was in flight makes this word stale.
            if (instr_rd_en_i && (addr_instr_i == mem_addr_o)) begin
              instr_o <= instr_sel;
              if_rdy  <= 1'b1;
            end
          end
          ARB_WR_WAIT: begin
            if (mem_wr_en_i) begin
              if (mem_rd_en_i) wr_done <= 1'b1;
              else             mem_rdy <= 1'b1;
            end
          end
          default: begin
            wr_done <= 1'b0;
            if (mem_rd_en_i) begin
              data_mem_o <= mem_rdata_i;
              mem_rdy    <= 1'b1;
            end
          end
        endcase
      end else if (expired) begin
        state     <= ARB_IDLE;
        mem_req_o <= 1'b0;
        bus_err_o <= 1'b1;
        case (state)
          ARB_IF_WAIT: begin
            instr_o <= '0;
            if_rdy  <= 1'b1;
          end
          ARB_WR_WAIT: begin
            mem_rdy <= 1'b1;
            wr_done <= 1'b0;
          end
          default: begin
            data_mem_o <= '0;
            mem_rdy    <= 1'b1;
            wr_done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a small slave answers after a programmable
// number of request cycles; each step is checked against hand-derived values.
module tb_mem_port_arb;

  logic        clk;
  logic        rst;
  logic        instr_rd_en_i;
  logic [63:0] addr_instr_i;
  logic        mem_rd_en_i;
  logic        mem_wr_en_i;
  logic [63:0] addr_mem_rd_i;
  logic [63:0] addr_mem_wr_i;
  logic [63:0] data_mem_wr_i;
  logic [7:0]  strb_mem_wr_i;
  logic [31:0] instr_o;
  logic [63:0] data_mem_o;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_strb_o;
  logic [63:0] mem_rdata_i;
  logic        mem_ack_i;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  int lat = 1;
  bit slave_en = 1'b1;
  bit ack_force = 1'b0;

  mem_port_arb #(
    .ADDR_W(64), .DATA_W(64), .INSTR_W(32), .TIMEOUT_CYC(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_rd_en_i (instr_rd_en_i),
    .addr_instr_i  (addr_instr_i),
    .mem_rd_en_i   (mem_rd_en_i),
    .mem_wr_en_i   (mem_wr_en_i),
    .addr_mem_rd_i (addr_mem_rd_i),
    .addr_mem_wr_i (addr_mem_wr_i),
    .data_mem_wr_i (data_mem_wr_i),
    .strb_mem_wr_i (strb_mem_wr_i),
    .instr_o       (instr_o),
    .data_mem_o    (data_mem_o),
    .stall_if      (stall_if),
    .stall_mem     (stall_mem),
    .bus_err_o     (bus_err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_strb_o    (mem_strb_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_ack_i     (mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then update the slave's ack for the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (mem_req_o === 1'b1) req_cnt++;
    else                    req_cnt = 0;
    mem_ack_i = ack_force | (slave_en & (mem_req_o === 1'b1) & (req_cnt == lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    instr_rd_en_i = 1'b0; addr_instr_i = '0;
    mem_rd_en_i = 1'b0; mem_wr_en_i = 1'b0;
    addr_mem_rd_i = '0; addr_mem_wr_i = '0;
    data_mem_wr_i = '0; strb_mem_wr_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;

    cyc(); cyc();
    check("rst_req",   {63'd0, mem_req_o}, 64'd0);
    check("rst_we",    {63'd0, mem_we_o},  64'd0);
    check("rst_addr",  mem_addr_o,         64'd0);
    check("rst_instr", {32'd0, instr_o},   64'd0);
    check("rst_data",  data_mem_o,         64'd0);
    check("rst_err",   {63'd0, bus_err_o}, 64'd0);
    check("rst_stall", {62'd0, stall_if, stall_mem}, 64'd0);
    rst = 1'b0;
    cyc();

    // Fetch only, ack on first request cycle, upper half selected.
    lat = 1; mem_rdata_i = 64'h11112222_33334444;
    instr_rd_en_i = 1'b1; addr_instr_i = 64'h8000_0004;
    #1 check("t1_c0_stall_if", {63'd0, stall_if}, 64'd1);
    cyc();
    check("t1_c1_req",     {63'd0, mem_req_o}, 64'd1);
    check("t1_c1_addr",    mem_addr_o,         64'h8000_0004);
    check("t1_c1_we",      {63'd0, mem_we_o},  64'd0);
    check("t1_c1_stall",   {63'd0, stall_if},  64'd1);
    cyc();
    check("t1_c2_req",     {63'd0, mem_req_o}, 64'd0);
    check("t1_c2_instr",   {32'd0, instr_o},   64'h1111_2222);
    check("t1_c2_stall",   {63'd0, stall_if},  64'd0);
    instr_rd_en_i = 1'b0;
    cyc();
    check("t1_c3_req",     {63'd0, mem_req_o}, 64'd0);

    // Fetch and load together: load served first, then fetch.
    lat = 3; mem_rdata_i = 64'hDEADBEEF_CAFEF00D;
    instr_rd_en_i = 1'b1; addr_instr_i = 64'h8000_0010;
    mem_rd_en_i = 1'b1; addr_mem_rd_i = 64'h8000_1000;
    cyc();
    check("t2_c1_addr",    mem_addr_o,         64'h8000_1000);
    check("t2_c1_we",      {63'd0, mem_we_o},  64'd0);
    cyc(); cyc();
    check("t2_c3_stalls",  {62'd0, stall_if, stall_mem}, 64'd3);
    cyc();
    check("t2_c4_data",    data_mem_o,         64'hDEADBEEF_CAFEF00D);
    check("t2_c4_stalls",  {62'd0, stall_if, stall_mem}, 64'd2);
    mem_rd_en_i = 1'b0; mem_rdata_i = 64'h01234567_89ABCDEF;
    n = 0;
    while (stall_if && n < 20) begin
      cyc();
      if (n == 0) check("t2_if_addr", mem_addr_o, 64'h8000_0010);
      n++;
    end
    check("t2_if_cycles",  n,                  64'd4);
    check("t2_instr",      {32'd0, instr_o},   64'h89AB_CDEF);
    instr_rd_en_i = 1'b0;
    cyc();

    // Store and load together: write, then read, one data stall.
    lat = 1; mem_rdata_i = 64'h55556666_77778888;
    mem_wr_en_i = 1'b1; addr_mem_wr_i = 64'h100;
    data_mem_wr_i = 64'hAAAABBBB_CCCCDDDD; strb_mem_wr_i = 8'h0F;
    mem_rd_en_i = 1'b1; addr_mem_rd_i = 64'h200;
    cyc();
    check("t3_c1_we",      {63'd0, mem_we_o},  64'd1);
    check("t3_c1_addr",    mem_addr_o,         64'h100);
    check("t3_c1_wdata",   mem_wdata_o,        64'hAAAABBBB_CCCCDDDD);
    check("t3_c1_strb",    {56'd0, mem_strb_o}, 64'h0F);
    cyc();
    check("t3_c2_req",     {63'd0, mem_req_o}, 64'd0);
    check("t3_c2_stall",   {63'd0, stall_mem}, 64'd1);
    check("t3_c2_data",    data_mem_o,         64'hDEADBEEF_CAFEF00D);
    cyc();
    check("t3_c3_req",     {63'd0, mem_req_o}, 64'd1);
    check("t3_c3_we",      {63'd0, mem_we_o},  64'd0);
    check("t3_c3_addr",    mem_addr_o,         64'h200);
    check("t3_c3_stall",   {63'd0, stall_mem}, 64'd1);
    cyc();
    check("t3_c4_data",    data_mem_o,         64'h55556666_77778888);
    check("t3_c4_stall",   {63'd0, stall_mem}, 64'd0);
    mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0;
    cyc();
    check("t3_c5_req",     {63'd0, mem_req_o}, 64'd0);

    // Fetch redirect: pc moves while the fetch is in flight.
    lat = 2; mem_rdata_i = 64'h12345678_9ABCDEF0;
    instr_rd_en_i = 1'b1; addr_instr_i = 64'h1000;
    cyc();
    check("t4_c1_addr",    mem_addr_o,         64'h1000);
    addr_instr_i = 64'h2000;
    cyc();
    cyc();
    check("t4_c3_req",     {63'd0, mem_req_o}, 64'd0);
    check("t4_c3_stall",   {63'd0, stall_if},  64'd1);
    check("t4_c3_instr",   {32'd0, instr_o},   64'h89AB_CDEF);
    mem_rdata_i = 64'hFEDCBA98_76543210;
    cyc();
    check("t4_c4_addr",    mem_addr_o,         64'h2000);
    cyc(); cyc();
    check("t4_c6_instr",   {32'd0, instr_o},   64'h7654_3210);
    check("t4_c6_stall",   {63'd0, stall_if},  64'd0);
    instr_rd_en_i = 1'b0;
    cyc();

    // Load with no ack: aborted after four wait cycles.
    slave_en = 1'b0;
    mem_rd_en_i = 1'b1; addr_mem_rd_i = 64'h300;
    cyc();
    check("t5_c1_req",     {63'd0, mem_req_o}, 64'd1);
    cyc(); cyc(); cyc();
    check("t5_c4_req",     {63'd0, mem_req_o}, 64'd1);
    check("t5_c4_err",     {63'd0, bus_err_o}, 64'd0);
    cyc();
    check("t5_c5_req",     {63'd0, mem_req_o}, 64'd0);
    check("t5_c5_err",     {63'd0, bus_err_o}, 64'd1);
    check("t5_c5_data",    data_mem_o,         64'd0);
    check("t5_c5_stall",   {63'd0, stall_mem}, 64'd0);
    mem_rd_en_i = 1'b0; ack_force = 1'b1; mem_ack_i = 1'b1;
    mem_rdata_i = 64'hBADBADBA_DBADBADB;
    cyc();
    check("t5_c6_err",     {63'd0, bus_err_o}, 64'd0);
    check("t5_c6_req",     {63'd0, mem_req_o}, 64'd0);
    check("t5_c6_data",    data_mem_o,         64'd0);
    ack_force = 1'b0; mem_ack_i = 1'b0;
    cyc();

    // Reset while a load is outstanding, then a clean fetch.
    mem_rd_en_i = 1'b1; addr_mem_rd_i = 64'h400;
    cyc();
    check("t6_c1_req",     {63'd0, mem_req_o}, 64'd1);
    rst = 1'b1; mem_rd_en_i = 1'b0;
    cyc();
    check("t6_rst_req",    {63'd0, mem_req_o}, 64'd0);
    check("t6_rst_addr",   mem_addr_o,         64'd0);
    check("t6_rst_instr",  {32'd0, instr_o},   64'd0);
    check("t6_rst_misc",   {60'd0, mem_we_o, bus_err_o, stall_if, stall_mem}, 64'd0);
    rst = 1'b0; slave_en = 1'b1; lat = 1;
    mem_rdata_i = 64'h0BADF00D_12345678;
    instr_rd_en_i = 1'b1; addr_instr_i = 64'h44;
    cyc();
    check("t6_f_addr",     mem_addr_o,         64'h44);
    cyc();
    check("t6_f_instr",    {32'd0, instr_o},   64'h0BAD_F00D);
    check("t6_f_stall",    {63'd0, stall_if},  64'd0);
    instr_rd_en_i = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
